// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

  localparam int                WORD_W   = 32;
  localparam logic [WORD_W-1:0] PC_STEP  = 32'd4;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {addr, inst} entries; flush outranks push and pop.
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  fetch_entry_t                i_push_data,
  input  logic                        i_pop,
  input  logic                        i_flush,
  output fetch_entry_t                o_head,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // NOTE: the storage array is deliberately left unreset; r_count alone
  // says which entries are live, so reset only touches the pointers.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch PC, single-outstanding imem request logic, branch discard and
// credit-limited issue feeding the prefetch FIFO.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = if_fetch_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  import if_fetch_pkg::*;

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  logic              r_req;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_fetch_pc;
  logic              r_discard;

  logic              w_xfer;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_next;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign w_xfer       = r_req && imem_ack;
  assign w_push       = w_xfer && !r_discard && !branch_taken;
  assign w_pop        = valid && !freeze && !branch_taken;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
  // Credit check: only issue if the word it returns is guaranteed a slot.
  assign w_issue      = (!r_req || w_xfer) && (w_count_next < DEPTH_C);
  assign w_push_data  = '{addr: r_addr, inst: imem_rdata};

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (branch_taken),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
    end else if (branch_taken) begin
      if (r_req && !w_xfer) begin
        // Request still in flight: let it finish, then drop its data.
        r_discard  <= 1'b1;
        r_fetch_pc <= branch_addr;
      end else begin
        r_req      <= 1'b1;
        r_addr     <= branch_addr;
        r_fetch_pc <= branch_addr + PC_STEP;
        r_discard  <= 1'b0;
      end
    end else begin
      if (w_xfer) r_discard <= 1'b0;
      if (w_issue) begin
        r_req      <= 1'b1;
        r_addr     <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end else if (w_xfer) begin
        r_req <= 1'b0;
      end
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign valid     = (w_count != '0);
  assign inst      = valid ? w_head.inst : '0;
  assign pc        = valid ? (w_head.addr + PC_STEP) : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, zero-wait and slow memory,
// freeze back-pressure, branch redirects and PC wrap-around.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;

  logic        w_ack = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;

  int vectors = 0;
  int errors  = 0;
  int lat     = 0;
  int wait_cnt = 0;
  bit manual  = 1'b0;
  bit man_ack = 1'b0;

  logic [31:0] exp_a, exp_p, exp_i;
  logic        exp_v;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .valid        (valid),
    .inst         (inst),
    .pc           (pc)
  );

  if_fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (2)
  ) dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ack     (w_ack),
    .imem_rdata   (w_rdata),
    .valid        (w_valid),
    .inst         (w_inst),
    .pc           (w_pc)
  );

  initial forever #5 clk = ~clk;

  // Memory model: word at address A is ~A; ack after 'lat' wait cycles,
  // or under direct control when 'manual' is set.
  initial forever begin
    @(negedge clk);
    if (!rst || !imem_req) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else if (manual) begin
      imem_ack = man_ack;
      wait_cnt = 0;
    end else if (wait_cnt == lat) begin
      imem_ack = 1'b1;
      wait_cnt = 0;
    end else begin
      imem_ack = 1'b0;
      wait_cnt++;
    end
    imem_rdata = imem_ack ? ~imem_addr : 32'h0;
    w_ack      = rst && w_req;
    w_rdata    = ~w_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    manual = 1'b0; man_ack = 1'b0; lat = 0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    vectors++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_req: got req=%b addr=%h expected req=0 addr=0", imem_req, imem_addr);
    end
    vectors++;
    if ({valid, inst, pc} !== {1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_out: got v=%b inst=%h pc=%h expected all zero", valid, inst, pc);
    end
    vectors++;
    if ({w_req, w_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_wrap: got req=%b v=%b expected 0 0", w_req, w_valid);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_a = 32'(4 * (k - 1));
      vectors++;
      if ({imem_req, imem_addr} !== {1'b1, exp_a}) begin
        errors++;
        $display("FAIL zw_addr k=%0d: got req=%b addr=%h expected 1 %h", k, imem_req, imem_addr, exp_a);
      end
      exp_v = (k >= 2);
      exp_p = exp_v ? exp_a : 32'h0;
      exp_i = exp_v ? ~(exp_a - 32'd4) : 32'h0;
      vectors++;
      if ({valid, pc, inst} !== {exp_v, exp_p, exp_i}) begin
        errors++;
        $display("FAIL zw_out k=%0d: got v=%b pc=%h inst=%h expected %b %h %h", k, valid, pc, inst, exp_v, exp_p, exp_i);
      end
    end
  endtask

  task automatic test_latency3();
    do_reset();
    lat = 3;
    for (int k = 1; k <= 13; k++) begin
      step();
      exp_a = 32'(4 * ((k - 1) / 4));
      vectors++;
      if ({imem_req, imem_addr} !== {1'b1, exp_a}) begin
        errors++;
        $display("FAIL lat3_addr k=%0d: got req=%b addr=%h expected 1 %h", k, imem_req, imem_addr, exp_a);
      end
      exp_v = (k >= 5) && ((k - 1) % 4 == 0);
      exp_p = exp_v ? exp_a : 32'h0;
      vectors++;
      if ({valid, pc} !== {exp_v, exp_p}) begin
        errors++;
        $display("FAIL lat3_out k=%0d: got v=%b pc=%h expected %b %h", k, valid, pc, exp_v, exp_p);
      end
    end
    lat = 0;
  endtask

  task automatic test_freeze();
    do_reset();
    repeat (3) step();
    freeze = 1'b1;
    for (int k = 4; k <= 9; k++) begin
      step();
      vectors++;
      if ({valid, pc, inst, imem_req} !== {1'b1, 32'h8, ~32'h4, 1'b0}) begin
        errors++;
        $display("FAIL freeze_hold k=%0d: got v=%b pc=%h inst=%h req=%b expected 1 00000008 %h 0", k, valid, pc, inst, imem_req, ~32'h4);
      end
    end
    freeze = 1'b0;
    for (int k = 10; k <= 12; k++) begin
      step();
      exp_p = 32'(4 * (k - 7));
      exp_i = ~(exp_p - 32'd4);
      vectors++;
      if ({valid, pc, inst, imem_req} !== {1'b1, exp_p, exp_i, 1'b1}) begin
        errors++;
        $display("FAIL freeze_drain k=%0d: got v=%b pc=%h inst=%h req=%b expected 1 %h %h 1", k, valid, pc, inst, imem_req, exp_p, exp_i);
      end
    end
  endtask

  task automatic test_branch_outstanding();
    do_reset();
    repeat (5) step();
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL br_pre: got req=%b addr=%h expected 1 00000010", imem_req, imem_addr);
    end
    manual = 1'b1; man_ack = 1'b0;
    branch_taken = 1'b1; branch_addr = 32'h100;
    step();
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) step();
      vectors++;
      if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10}) begin
        errors++;
        $display("FAIL br_hold k=%0d: got v=%b req=%b addr=%h expected 0 1 00000010", k, valid, imem_req, imem_addr);
      end
    end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0; manual = 1'b0;
    vectors++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL br_drop: got v=%b req=%b addr=%h expected 0 1 00000100", valid, imem_req, imem_addr);
    end
    step();
    vectors++;
    if ({valid, pc, inst, imem_addr} !== {1'b1, 32'h104, ~32'h100, 32'h104}) begin
      errors++;
      $display("FAIL br_first: got v=%b pc=%h inst=%h addr=%h expected 1 00000104 %h 00000104", valid, pc, inst, imem_addr, ~32'h100);
    end
    step();
    vectors++;
    if ({valid, pc, inst} !== {1'b1, 32'h108, ~32'h104}) begin
      errors++;
      $display("FAIL br_second: got v=%b pc=%h inst=%h expected 1 00000108 %h", valid, pc, inst, ~32'h104);
    end
  endtask

  task automatic test_branch_xfer_freeze();
    do_reset();
    repeat (3) step();
    freeze = 1'b1;
    branch_taken = 1'b1; branch_addr = 32'h200;
    step();
    branch_taken = 1'b0;
    vectors++;
    if ({valid, inst, pc, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL bx_redirect: got v=%b inst=%h pc=%h req=%b addr=%h expected 0 0 0 1 00000200", valid, inst, pc, imem_req, imem_addr);
    end
    step();
    vectors++;
    if ({valid, pc, inst, imem_addr} !== {1'b1, 32'h204, ~32'h200, 32'h204}) begin
      errors++;
      $display("FAIL bx_first: got v=%b pc=%h inst=%h addr=%h expected 1 00000204 %h 00000204", valid, pc, inst, imem_addr, ~32'h200);
    end
    step();
    vectors++;
    if ({valid, pc, imem_req} !== {1'b1, 32'h204, 1'b0}) begin
      errors++;
      $display("FAIL bx_full: got v=%b pc=%h req=%b expected 1 00000204 0", valid, pc, imem_req);
    end
    freeze = 1'b0;
    step();
    vectors++;
    if ({valid, pc, imem_req, imem_addr} !== {1'b1, 32'h208, 1'b1, 32'h208}) begin
      errors++;
      $display("FAIL bx_release: got v=%b pc=%h req=%b addr=%h expected 1 00000208 1 00000208", valid, pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_a = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
      vectors++;
      if ({w_req, w_addr} !== {1'b1, exp_a}) begin
        errors++;
        $display("FAIL wrap_addr k=%0d: got req=%b addr=%h expected 1 %h", k, w_req, w_addr, exp_a);
      end
      if (k >= 2) begin
        vectors++;
        if ({w_valid, w_pc, w_inst} !== {1'b1, exp_a, ~(exp_a - 32'd4)}) begin
          errors++;
          $display("FAIL wrap_out k=%0d: got v=%b pc=%h inst=%h expected 1 %h %h", k, w_valid, w_pc, w_inst, exp_a, ~(exp_a - 32'd4));
        end
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({imem_req, valid, pc, inst, w_req, w_valid} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got req=%b v=%b pc=%h inst=%h wreq=%b wv=%b expected all zero", imem_req, valid, pc, inst, w_req, w_valid);
    end
    step();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency3();
    test_freeze();
    test_branch_outstanding();
    test_branch_xfer_freeze();
    test_wrap_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the five-stage ARM pipeline. Owns the fetch PC and issues one-at-a-time word requests to a variable-latency instruction memory. Buffers returned words in a small prefetch FIFO and presents them, with their PC+4, to the IF stage register. Honours the hazard-unit freeze and EXE-stage branch redirects, discarding in-flight and buffered wrong-path words.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 2: prefetch entries; a power of two, ≥2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `freeze`  in  1  downstream stall: hold the presented word and do not pop.
- `branch_taken`  in  1  one-cycle redirect strobe from EXE.
- `branch_addr`  in  32  redirect target, word aligned.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  32  fetch address, registered; stable while `imem_req`=1.
- `imem_ack`  in  1  read data valid; a transfer is any cycle with `imem_req && imem_ack`.
- `imem_rdata`  in  32  instruction word, sampled on transfer.
- `valid`  out  1  `inst`/`pc` hold a correct-path instruction.
- `inst`  out  32  FIFO head word; 32'h0 when `valid`=0.
- `pc`  out  32  head fetch address + 4; 32'h0 when `valid`=0.

## Operation
- **Reset** (`rst`=0, immediate): `imem_req`=0, `imem_addr`=0, fetch_pc=`RESET_PC`, FIFO empty, discard flag=0, `valid`=0, `inst`=0, `pc`=0. An abandoned memory request is the memory's concern.
- **Outstanding:** at most one request. `imem_req` rises only when none is outstanding or a transfer completes this cycle.
- **Issue** at an edge when (`!imem_req` or transfer) and `!branch_taken` and (count_next + 1 ≤ `FIFO_DEPTH`).
  - count_next = count + push − pop.
  - Effect: `imem_req`←1, `imem_addr`←fetch_pc, fetch_pc←fetch_pc+4 (mod 2^32; wraps 32'hFFFF_FFFC→0).
  - Otherwise, on transfer, `imem_req`←0.
- **Push:** a transfer with discard=0 writes {`imem_addr`, `imem_rdata`} to the FIFO tail. The credit rule guarantees no overflow.
- **Pop:** `valid && !freeze && !branch_taken`. Push and pop in one cycle are both performed.
- **Branch** (priority over freeze, issue, push and pop):
  - FIFO cleared at the edge.
  - If a request is outstanding without a transfer this cycle: discard←1, `imem_req`/`imem_addr` held, fetch_pc←`branch_addr`. On that request's transfer, its data is dropped, discard←0, and the issue rule applies.
  - If no request is outstanding, or a transfer occurs this cycle (its data dropped): `imem_req`←1, `imem_addr`←`branch_addr`, fetch_pc←`branch_addr`+4.
  - A second `branch_taken` while discard=1 only overwrites fetch_pc.
- `freeze` never blocks memory traffic; the FIFO fills and issue stops at the credit limit.

## Timing
- The first `imem_req` is asserted at the first edge after `rst` deasserts.
- With a zero-wait memory (ack in the request cycle):
  - First `valid` comes 2 edges after reset release.
  - Sustained throughput is 1 word/cycle.
  - Branch-to-valid latency is 2 edges.
- With N-cycle ack latency, throughput is 1 word per N+1 cycles, because requests are non-pipelined.
- `valid`, `inst` and `pc` are the FIFO head and change only at edges.
- `imem_ack` while `imem_req`=0 is ignored.

## Structure
- Package `if_fetch_pkg`: `WORD_W`=32, `PC_STEP`=4, `RESET_PC` default, and the `fetch_entry_t` struct {addr, inst}.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, and `FIFO_DEPTH` parameter. Flush has priority over push.
- The top module holds fetch_pc, the request registers, the discard flag, and the issue/credit logic.

## Test plan
- **Reset, zero-wait memory, `freeze`=0:** `imem_addr` = 0, 4, 8… on consecutive cycles; `valid`=1 from edge 2 with `pc`=4, 8, 12…; `inst` matches memory.
- **3-cycle ack latency:** one request per 4 cycles; `imem_addr` stable while `imem_req`=1; never two outstanding.
- **`freeze` held 6 cycles, zero-wait:** `inst`/`pc` constant; exactly `FIFO_DEPTH` words buffered; `imem_req` drops. On release, words pop in order with no loss or duplication.
- **`branch_taken` to 0x100 with a request to 0x10 outstanding, acked 2 cycles later:** 0x10 data dropped; next `imem_addr`=0x100; first valid `pc`=0x104; no stale entries.
- **`branch_taken` in the same cycle as a transfer and `freeze`=1:** FIFO cleared, data dropped, `imem_addr`←target next edge.
- **`RESET_PC`=32'hFFFF_FFF8:** fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Also assert `rst` low mid-request: `imem_req` and `valid` drop immediately.
